// File: rtl/mips_mem_responder_if.sv
// rtl/mips_mem_responder_if.sv - request/response and preload bundle between the MIPS core and its memory
interface mips_mem_responder_if #(
    parameter int ADDR_WIDTH = 10
) ();
    logic                  MemRead;
    logic                  MemWrite;
    logic [31:0]           address;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  ready;
    logic                  busy;
    logic                  err_align;
    logic                  err_range;
    logic                  err_op;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [31:0]           load_data;

    modport master (
        output MemRead, MemWrite, address, wdata, load_en, load_addr, load_data,
        input  rdata, ready, busy, err_align, err_range, err_op
    );

    modport slave (
        input  MemRead, MemWrite, address, wdata, load_en, load_addr, load_data,
        output rdata, ready, busy, err_align, err_range, err_op
    );
endinterface

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - unified word RAM answering MIPS core requests through an IDLE/WAIT/ACCESS/RESP FSM
module mips_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  op_write_q, op_write_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_align_q, err_align_d;
    logic                  err_range_q, err_range_d;
    logic                  err_op_q, err_op_d;

    logic [31:0]           mem [0:DEPTH-1];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    logic                  acc_misaligned;
    logic                  acc_out_of_range;
    logic [ADDR_WIDTH-1:0] acc_index;

    assign acc_misaligned   = (addr_q[1:0] != 2'b00);
    assign acc_out_of_range = |addr_q[31:ADDR_WIDTH+2];
    assign acc_index        = addr_q[ADDR_WIDTH+1:2];

    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        err_align_d = err_align_q;
        err_range_d = err_range_q;
        err_op_d    = err_op_q;
        mem_we      = 1'b0;
        mem_waddr   = bus.load_addr;
        mem_wdata   = bus.load_data;

        case (state_q)
            S_IDLE: begin
                if (bus.MemRead && bus.MemWrite) begin
                    err_op_d = 1'b1;
                end
                // Preload has priority; a level request simply gets accepted one cycle later.
                if (bus.load_en) begin
                    mem_we = 1'b1;
                end else if (bus.MemRead ^ bus.MemWrite) begin
                    op_write_d = bus.MemWrite;
                    addr_d     = bus.address;
                    wdata_d    = bus.wdata;
                    cnt_d      = 4'd1;
                    state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_CYCLES)) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                if (acc_misaligned) err_align_d = 1'b1;
                if (acc_out_of_range) err_range_d = 1'b1;
                if (op_write_q) begin
                    if (!acc_misaligned && !acc_out_of_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = acc_index;
                        mem_wdata = wdata_q;
                    end
                end else begin
                    rdata_d = (acc_misaligned || acc_out_of_range) ? 32'h0 : mem[acc_index];
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_write_q  <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            cnt_q       <= 4'd0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            err_align_q <= err_align_d;
            err_range_q <= err_range_d;
            err_op_q    <= err_op_d;
        end
    end

    // Array contents survive reset; only the write in the reset cycle is blocked.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.ready     = (state_q == S_RESP);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err_align = err_align_q;
    assign bus.err_range = err_range_q;
    assign bus.err_op    = err_op_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed self-checking bench for mips_mem_responder with 0 and 3 wait states
module tb_mips_mem_responder;
    logic clk = 1'b0;
    logic rst0;
    logic rst3;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_mem_responder_if #(.ADDR_WIDTH(10)) bus0 ();
    mips_mem_responder_if #(.ADDR_WIDTH(10)) bus3 ();

    mips_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.slave)
    );

    mips_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3.slave)
    );

    task automatic drive_req(input bit d3, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (d3) begin
            bus3.MemRead = rd; bus3.MemWrite = wr; bus3.address = a; bus3.wdata = d;
        end else begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.address = a; bus0.wdata = d;
        end
    endtask

    task automatic access(input bit d3, input bit wr, input logic [31:0] a, input logic [31:0] d, output int lat);
        drive_req(d3, !wr, wr, a, d);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((d3 ? bus3.ready : bus0.ready) === 1'b1) begin
                lat = i;
                break;
            end
        end
        drive_req(d3, 1'b0, 1'b0, a, d);
        @(negedge clk);
    endtask

    task automatic preload(input bit d3, input logic [9:0] a, input logic [31:0] d);
        if (d3) begin
            bus3.load_en = 1'b1; bus3.load_addr = a; bus3.load_data = d;
        end else begin
            bus0.load_en = 1'b1; bus0.load_addr = a; bus0.load_data = d;
        end
        @(negedge clk);
        bus0.load_en = 1'b0;
        bus3.load_en = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus0.rdata !== 32'h0 || bus0.ready !== 1'b0 || bus0.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h ready=%b busy=%b, expected 0/0/0", bus0.rdata, bus0.ready, bus0.busy);
        end
        checks++;
        if ({bus0.err_align, bus0.err_range, bus0.err_op} !== 3'b000) begin
            errors++;
            $display("FAIL reset_errs: got %b expected 000", {bus0.err_align, bus0.err_range, bus0.err_op});
        end
        checks++;
        if (bus3.busy !== 1'b0 || bus3.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_dut3: busy=%b rdata=%h expected 0/0", bus3.busy, bus3.rdata);
        end
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_preload_read();
        int lat;
        for (int i = 0; i < 4; i++) begin
            preload(1'b0, 10'(i), 32'h11111111 * (i + 1));
            preload(1'b1, 10'(i), 32'h11111111 * (i + 1));
        end
        access(1'b0, 1'b0, 32'h8, 32'h0, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL read_latency: got %0d expected 2", lat);
        end
        checks++;
        if (bus0.rdata !== 32'h33333333) begin
            errors++;
            $display("FAIL read_word2: got %h expected 33333333", bus0.rdata);
        end
        // Cycle-by-cycle trace of busy/ready for a read of word 0
        drive_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b1 || bus0.ready !== 1'b0) begin
            errors++;
            $display("FAIL trace_access: busy=%b ready=%b expected 1/0", bus0.busy, bus0.ready);
        end
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b1 || bus0.ready !== 1'b1 || bus0.rdata !== 32'h11111111) begin
            errors++;
            $display("FAIL trace_resp: busy=%b ready=%b rdata=%h expected 1/1/11111111", bus0.busy, bus0.ready, bus0.rdata);
        end
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0 || bus0.ready !== 1'b0) begin
            errors++;
            $display("FAIL trace_idle: busy=%b ready=%b expected 0/0", bus0.busy, bus0.ready);
        end
    endtask

    task automatic test_write_read();
        int lat;
        access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL write_latency: got %0d expected 2", lat);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, lat);
        checks++;
        if (bus0.rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL write_readback: got %h expected cafef00d", bus0.rdata);
        end
        checks++;
        if ({bus0.err_align, bus0.err_range, bus0.err_op} !== 3'b000) begin
            errors++;
            $display("FAIL write_no_errs: got %b expected 000", {bus0.err_align, bus0.err_range, bus0.err_op});
        end
    endtask

    task automatic test_wait_states();
        int lat = -1;
        drive_req(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus3.address = 32'hC;
                bus3.wdata   = 32'hA5A5A5A5;
            end
            if (bus3.ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL wait_latency: got %0d expected 5", lat);
        end
        checks++;
        if (bus3.rdata !== 32'h22222222) begin
            errors++;
            $display("FAIL wait_captured_addr: got %h expected 22222222", bus3.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_align();
        int lat;
        access(1'b0, 1'b1, 32'h6, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL align_latency: got %0d expected 2", lat);
        end
        checks++;
        if (bus0.err_align !== 1'b1 || bus0.rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL align_flag: err_align=%b rdata=%h expected 1/cafef00d", bus0.err_align, bus0.rdata);
        end
        access(1'b0, 1'b0, 32'h4, 32'h0, lat);
        checks++;
        if (bus0.rdata !== 32'h22222222 || bus0.err_align !== 1'b1) begin
            errors++;
            $display("FAIL align_suppressed: rdata=%h err_align=%b expected 22222222/1", bus0.rdata, bus0.err_align);
        end
        access(1'b0, 1'b0, 32'h5, 32'h0, lat);
        checks++;
        if (bus0.rdata !== 32'h0 || lat !== 2) begin
            errors++;
            $display("FAIL align_read: rdata=%h lat=%0d expected 0/2", bus0.rdata, lat);
        end
    endtask

    task automatic test_range();
        int lat;
        access(1'b0, 1'b0, 32'h8, 32'h0, lat);
        access(1'b0, 1'b0, 32'h00001000, 32'h0, lat);
        checks++;
        if (bus0.rdata !== 32'h0 || bus0.err_range !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL range_read: rdata=%h err_range=%b lat=%0d expected 0/1/2", bus0.rdata, bus0.err_range, lat);
        end
        checks++;
        if (bus0.err_op !== 1'b0) begin
            errors++;
            $display("FAIL range_no_op: err_op=%b expected 0", bus0.err_op);
        end
    endtask

    task automatic test_op_conflict();
        bit saw = 1'b0;
        drive_req(1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus0.ready !== 1'b0 || bus0.busy !== 1'b0) saw = 1'b1;
        end
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL op_no_accept: ready/busy seen=%b expected 0", saw);
        end
        checks++;
        if (bus0.err_op !== 1'b1) begin
            errors++;
            $display("FAIL op_flag: err_op=%b expected 1", bus0.err_op);
        end
        @(negedge clk);
    endtask

    task automatic test_load_priority();
        int lat = -1;
        bus0.load_en = 1'b1; bus0.load_addr = 10'd5; bus0.load_data = 32'h55AA55AA;
        drive_req(1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus0.load_en = 1'b0;
            if (bus0.ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (lat !== 3 || bus0.rdata !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL load_priority: lat=%0d rdata=%h expected 3/55aa55aa", lat, bus0.rdata);
        end
    endtask

    task automatic test_load_busy();
        int lat;
        drive_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        bus0.load_en = 1'b1; bus0.load_addr = 10'd0; bus0.load_data = 32'hBAD0BAD0;
        @(negedge clk);
        bus0.load_en = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        access(1'b0, 1'b0, 32'h0, 32'h0, lat);
        checks++;
        if (bus0.rdata !== 32'h11111111) begin
            errors++;
            $display("FAIL load_ignored_busy: got %h expected 11111111", bus0.rdata);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw = 1'b0;
        drive_req(1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF);
        @(negedge clk);
        rst3 = 1'b1;
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (bus3.busy !== 1'b0 || bus3.rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_state: busy=%b rdata=%h expected 0/0", bus3.busy, bus3.rdata);
        end
        rst3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus3.ready !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_ready: seen=%b expected 0", saw);
        end
        access(1'b1, 1'b0, 32'h0, 32'h0, lat);
        checks++;
        if (bus3.rdata !== 32'h11111111 || lat !== 5) begin
            errors++;
            $display("FAIL rst_mid_ram: rdata=%h lat=%0d expected 11111111/5", bus3.rdata, lat);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus0.load_en = 1'b0; bus0.load_addr = '0; bus0.load_data = '0;
        bus3.load_en = 1'b0; bus3.load_addr = '0; bus3.load_data = '0;
        @(negedge clk);
        test_reset();
        test_preload_read();
        test_write_read();
        test_wait_states();
        test_align();
        test_range();
        test_op_conflict();
        test_load_priority();
        test_load_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
